song_sequencer_ctrl: RTL

//  Parametrised successor to the single-song reader FSM. It sequences note addresses through a song ROM
//  for a selectable number of songs and handshakes each note with the note player (new_note / note_done).

---
 rtl/song_sequencer_ctrl_if.sv | 34 +++
 rtl/song_sequencer_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/song_sequencer_ctrl_if.sv
// Handshake/control bundle between the user-control side, the song ROM / note player
// and song_sequencer_ctrl.
//   play, stop, next_song, repeat_en : user controls (debounced)
//   note_done, note_end              : note player finish pulse, ROM end-of-song marker
//   song, note_addr                  : ROM address (upper / lower)
//   new_note, song_done, busy        : player load pulse, end-of-song pulse, activity flag
// The slave modport is the sequencer's view; master is the view of whatever drives it.
// ADDR_W/SONG_W must match the parameters of the attached sequencer.
interface song_sequencer_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SONG_W = 2
) ();
  logic              play;
  logic              stop;
  logic              next_song;
  logic              repeat_en;
  logic              note_done;
  logic              note_end;
  logic [SONG_W-1:0] song;
  logic [ADDR_W-1:0] note_addr;
  logic              new_note;
  logic              song_done;
  logic              busy;

  modport master (
    output play, stop, next_song, repeat_en, note_done, note_end,
    input  song, note_addr, new_note, song_done, busy
  );

  modport slave (
    input  play, stop, next_song, repeat_en, note_done, note_end,
    output song, note_addr, new_note, song_done, busy
  );
endinterface

// File: rtl/song_sequencer_ctrl.sv
// Song sequencer: walks note addresses through a song ROM for 2**SONG_W songs and
// handshakes each note with the note player (new_note / note_done). Supports pause/resume
// with position kept, end-of-song marker and implicit end at the last address, repeat
// mode, stop (rewind) and skip to next song.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : song_sequencer_ctrl_if.slave (controls in, ROM address / player handshake out)
module song_sequencer_ctrl #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SONG_W  = 2,
  parameter int unsigned ROM_LAT = 1
) (
  input logic                  clk,
  input logic                  reset,
  song_sequencer_ctrl_if.slave bus
);

  localparam int unsigned CntW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CntW-1:0]   FetchLast = CntW'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] AddrLast  = '1;

  typedef enum logic [2:0] {StIdle, StFetch, StNewNote, StWait, StPause, StNext} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] note_addr_q, note_addr_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [CntW-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic              done_pend_q, done_pend_d;
  logic              play_d_q, play_d_d;
  logic              song_done_q, song_done_d;
  logic              song_end;
  logic              pend_now;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      note_addr_q <= '0;
      song_q      <= '0;
      fetch_cnt_q <= '0;
      done_pend_q <= 1'b0;
      play_d_q    <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      note_addr_q <= note_addr_d;
      song_q      <= song_d;
      fetch_cnt_q <= fetch_cnt_d;
      done_pend_q <= done_pend_d;
      play_d_q    <= play_d_d;
      song_done_q <= song_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    note_addr_d = note_addr_q;
    song_d      = song_q;
    fetch_cnt_d = '0;  // every entry into FETCH starts the latency count from zero
    done_pend_d = done_pend_q;
    play_d_d    = bus.play;
    song_done_d = 1'b0;
    song_end    = 1'b0;
    // A note_done arriving in the resume cycle itself must not be lost.
    pend_now    = done_pend_q | bus.note_done;

    if (bus.stop) begin
      note_addr_d = '0;
      done_pend_d = 1'b0;
      state_d     = StIdle;
    end else if (bus.next_song) begin
      song_d      = song_q + SONG_W'(1);
      note_addr_d = '0;
      done_pend_d = 1'b0;
      state_d     = (state_q == StIdle || state_q == StPause) ? StIdle : StFetch;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.play && !play_d_q) state_d = StFetch;
        end
        StFetch: begin
          if (fetch_cnt_q == FetchLast) begin
            if (bus.note_end) song_end = 1'b1;
            else              state_d  = StNewNote;
          end else begin
            fetch_cnt_d = fetch_cnt_q + CntW'(1);
          end
        end
        StNewNote: state_d = StWait;
        StWait: begin
          if (!bus.play) begin
            state_d     = StPause;
            done_pend_d = bus.note_done;
          end else if (bus.note_done) begin
            state_d = StNext;
          end
        end
        StPause: begin
          if (bus.play) begin
            state_d     = pend_now ? StNext : StWait;
            done_pend_d = 1'b0;
          end else begin
            done_pend_d = pend_now;
          end
        end
        StNext: begin
          if (note_addr_q == AddrLast) begin
            song_end = 1'b1;
          end else begin
            note_addr_d = note_addr_q + ADDR_W'(1);
            state_d     = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase

      if (song_end) begin
        song_done_d = 1'b1;
        note_addr_d = '0;
        if (bus.repeat_en) begin
          state_d = StFetch;
        end else begin
          song_d  = song_q + SONG_W'(1);
          state_d = StIdle;
        end
      end
    end
  end

  always_comb begin
    bus.song      = song_q;
    bus.note_addr = note_addr_q;
    bus.song_done = song_done_q;
    bus.new_note  = (state_q == StNewNote);
    bus.busy      = (state_q == StFetch) || (state_q == StNewNote) ||
                    (state_q == StWait)  || (state_q == StNext);
  end

endmodule
